input_port_router: RTL and testbench
====================================

# input_port_router

Receive-side counterpart of the per-port output arbiter: one instance per router input link (N/S/E/W). It accepts packets from the neighbouring router's output arbiter, buffers them in a FIFO, and computes a dimension-ordered (X-then-Y) route for the head packet. It then either raises one directional select bit toward this router's output arbiters or presents the packet to the local cache bank. Head-of-line packets wait under a grant/accept handshake, so nothing is lost downstream of the FIFO.

## Interface
- `ROUTER_X`, 0, this router's X coordinate (upper half of `NETWORK_ADDRESS_WIDTH`)
- `ROUTER_Y`, 0, this router's Y coordinate (lower half of `NETWORK_ADDRESS_WIDTH`)
- `DEPTH`, 4, FIFO entries (power of two, 2..16)
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted)
- `readIn`, `writeIn`  input  1  packet valid when either is 1
- `destinationAddressIn`  input  `NETWORK_ADDRESS_WIDTH`+`CACHE_BANK_ADDRESS_WIDTH`  destination {node, bank}
- `requesterAddressIn`  input  `NETWORK_ADDRESS_WIDTH`  originating node
- `dataIn`  input  `DATA_WIDTH`  payload
- `full`  output  1  FIFO holds `DEPTH` entries; upstream must not send
- `selectBit_NORTH`, `selectBit_SOUTH`, `selectBit_EAST`, `selectBit_WEST`  output  1  head packet routed to that output arbiter (at most one high)
- `grant`  input  4  {WEST, EAST, SOUTH, NORTH}: output arbiter accepted the packet this cycle
- `cacheValid`  output  1  head packet is for the local bank
- `cacheAccept`  input  1  local cache arbiter took the packet this cycle
- `destinationAddressOut`, `requesterAddressOut`, `readOut`, `writeOut`, `dataOut`  output  same widths as inputs  head-packet bus, shared by all arbiters and the cache
- `errorCount`  output  8  dropped-packet count (see Configuration)

## Operation
- Push: a packet is valid when `readIn|writeIn`. It is written at the tail if count<`DEPTH`, or if count==`DEPTH` and a pop occurs in the same cycle. Otherwise it is dropped.
- A valid packet with both `readIn` and `writeIn` = 1 is malformed and is always dropped.
- Route decode uses dX = dest node upper half and dY = lower half:
  - dX>`ROUTER_X` → EAST; dX<`ROUTER_X` → WEST.
  - Otherwise dY>`ROUTER_Y` → SOUTH; dY<`ROUTER_Y` → NORTH.
  - Otherwise → LOCAL.
- FSM states:
  - IDLE: FIFO empty; all selects, `cacheValid`, `readOut` and `writeOut` are 0. Go to ROUTE when count becomes ≥1.
  - ROUTE: one cycle; decode the head and register the direction. Go to SEND.
  - SEND: drive the head fields on the output bus and assert the registered select bit (or `cacheValid`). Hold until the matching `grant` bit (or `cacheAccept`) is 1. That cycle pops the head; next state is ROUTE if entries remain after the pop, else IDLE.
- Grant bits for unselected directions are ignored.
- The output bus is stable and unchanged throughout SEND.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `log2(DEPTH)+1` bits.

## Timing
- Reset values: all selects 0, `cacheValid` 0, `readOut` 0, `writeOut` 0, other bus fields 0, `full` 0, `errorCount` 0, FIFO empty, state IDLE.
- Reset mid-operation flushes all entries immediately (asynchronous). The first valid push is sampled at the first rising edge with `reset`=1.
- Latency: a packet sampled at edge 0 into an empty FIFO gives ROUTE in cycle 1 and SEND with select asserted after edge 2. Minimum 2 cycles from input to select.
- Sustained throughput: one packet per 2 cycles (ROUTE+SEND, with grant in the first SEND cycle).
- `full` is registered and reflects the count after each edge.
- Simultaneous push and pop with count==`DEPTH`: the push is accepted, count stays `DEPTH`, `full` stays 1.

## Configuration
- `INPUT_PORT_ERROR_COUNT_EN` defined: `errorCount` increments once per dropped packet (overflow or malformed). It saturates at 255 and clears only on reset.
- Macro undefined: no counter logic; `errorCount` is tied to 0. Drop behaviour is unchanged.

## Test plan
- Router (1,1), dest node X=3,Y=1, `readIn`=1, `dataIn`=0xA5 → `selectBit_EAST`=1 two cycles later with `dataOut`=0xA5 and `readOut`=1; `grant`=0001b is ignored, then `grant`=0100b pops → IDLE.
- Dest X=1,Y=1, `writeIn`=1 → `cacheValid`=1 with no select bit; hold `cacheAccept`=0 for 5 cycles → bus unchanged; `cacheAccept`=1 → pop.
- Push 5 packets with `DEPTH`=4 and no grants → `full`=1 after the 4th; 5th dropped; `errorCount`=1 (macro on) or 0 (macro off).
- With the FIFO full, push while granting the head in the same cycle → push accepted, count stays 4, packets delivered in FIFO order.
- Send a packet with `readIn`=`writeIn`=1 → dropped, never routed; `errorCount` increments (macro on).
- Push 3 packets, then assert `reset`=0 for one cycle mid-SEND → selects drop to 0 immediately; after release the FIFO is empty and `full`=0.

Source files
------------

// File: rtl/input_port_router.sv
// input_port_router: input-link FIFO with X-then-Y route decode and a grant/accept handshake.
// Define INPUT_PORT_ERROR_COUNT_EN to count dropped packets on errorCount.
module input_port_router #(
  parameter int NETWORK_ADDRESS_WIDTH = 4,
  parameter int CACHE_BANK_ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic readIn,
  input  logic writeIn,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic full,
  output logic selectBit_NORTH,
  output logic selectBit_SOUTH,
  output logic selectBit_EAST,
  output logic selectBit_WEST,
  input  logic [3:0] grant,
  output logic cacheValid,
  input  logic cacheAccept,
  output logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressOut,
  output logic readOut,
  output logic writeOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [7:0] errorCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = NETWORK_ADDRESS_WIDTH / 2;
  localparam int EW = 2 + NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH + NETWORK_ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] RX = HW'(ROUTER_X);
  localparam logic [HW-1:0] RY = HW'(ROUTER_Y);
  typedef enum logic [1:0] {IDLE, ROUTE, SEND} state_t;
  state_t state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic [3:0] sel, dir;
  logic [HW-1:0] dx, dy;
  logic valid, push, pop;
  assign valid = readIn | writeIn;
  assign pop = state == SEND && ((|(sel & grant)) || (cacheValid && cacheAccept));
  assign push = valid && !(readIn && writeIn) && (count < FULL || pop);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign dx = mem[rd_ptr][EW-3 -: HW];
  assign dy = mem[rd_ptr][EW-3-HW -: HW];
  // dir bit order matches grant: {WEST, EAST, SOUTH, NORTH}; zero means local bank
  assign dir = dx > RX ? 4'b0100 : dx < RX ? 4'b1000 : dy > RY ? 4'b0010 : dy < RY ? 4'b0001 : 4'b0000;
  assign {selectBit_WEST, selectBit_EAST, selectBit_SOUTH, selectBit_NORTH} = sel;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {readIn, writeIn, destinationAddressIn, requesterAddressIn, dataIn};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      sel <= '0;
      cacheValid <= 1'b0;
      readOut <= 1'b0;
      writeOut <= 1'b0;
      destinationAddressOut <= '0;
      requesterAddressOut <= '0;
      dataOut <= '0;
    end else begin
      count <= count_next;
      full <= count_next == FULL;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case (state)
        IDLE: if (count != '0) state <= ROUTE;
        ROUTE: begin
          state <= SEND;
          sel <= dir;
          cacheValid <= dir == 4'b0000;
          {readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut} <= mem[rd_ptr];
        end
        default: if (pop) begin
          state <= count_next != '0 ? ROUTE : IDLE;
          sel <= '0;
          cacheValid <= 1'b0;
          readOut <= 1'b0;
          writeOut <= 1'b0;
        end
      endcase
    end
`ifdef INPUT_PORT_ERROR_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) errorCount <= '0;
    else if (valid && !push && errorCount != 8'hff) errorCount <= errorCount + 8'd1;
`else
  assign errorCount = '0;
`endif
endmodule

// File: tb/tb_input_port_router.sv
// tb_input_port_router: scoreboard bench for input_port_router at router (1,1), DEPTH 4.
module tb_input_port_router;
  logic clk = 0, reset = 0, readIn = 0, writeIn = 0, cacheAccept = 0;
  logic [5:0] destinationAddressIn = 0, destinationAddressOut;
  logic [3:0] requesterAddressIn = 0, requesterAddressOut, grant = 0;
  logic [7:0] dataIn = 0, dataOut, errorCount;
  logic full, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST;
  logic cacheValid, readOut, writeOut;
  int total = 0, bad = 0;
  logic [24:0] sb [$];
  input_port_router #(.NETWORK_ADDRESS_WIDTH(4), .CACHE_BANK_ADDRESS_WIDTH(2), .DATA_WIDTH(8),
    .ROUTER_X(1), .ROUTER_Y(1), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .readIn(readIn), .writeIn(writeIn),
    .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn), .dataIn(dataIn),
    .full(full), .selectBit_NORTH(selectBit_NORTH), .selectBit_SOUTH(selectBit_SOUTH),
    .selectBit_EAST(selectBit_EAST), .selectBit_WEST(selectBit_WEST), .grant(grant),
    .cacheValid(cacheValid), .cacheAccept(cacheAccept), .destinationAddressOut(destinationAddressOut),
    .requesterAddressOut(requesterAddressOut), .readOut(readOut), .writeOut(writeOut),
    .dataOut(dataOut), .errorCount(errorCount));
  always #5 clk = ~clk;
  function automatic logic [24:0] pk(logic [3:0] s, logic cv, logic r, logic w, logic [5:0] d, logic [3:0] q, logic [7:0] x);
    return {s, cv, r, w, d, q, x};
  endfunction
  function automatic logic [3:0] sel();
    return {selectBit_WEST, selectBit_EAST, selectBit_SOUTH, selectBit_NORTH};
  endfunction
  function automatic logic [24:0] outs();
    return pk(sel(), cacheValid, readOut, writeOut, destinationAddressOut, requesterAddressOut, dataOut);
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  // monitor: every accepted handshake must match the oldest expected delivery
  always @(negedge clk)
    if (reset && ((|(sel() & grant)) || (cacheValid && cacheAccept))) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL deliver_unexpected got=%0h expected=none", outs());
      end else check("deliver", 32'(outs()), 32'(sb.pop_front()));
    end
  task automatic drive(logic r, logic w, logic [5:0] d, logic [3:0] q, logic [7:0] x);
    readIn = r;
    writeIn = w;
    destinationAddressIn = d;
    requesterAddressIn = q;
    dataIn = x;
    @(posedge clk);
    #1;
    readIn = 0;
    writeIn = 0;
  endtask
  task automatic wait_valid(string name);
    int n = 0;
    while (!((|sel()) || cacheValid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check(name, 0, 1);
  endtask
  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin
      wait_valid("drain_timeout");
      @(posedge clk);
      #1;
      grant = sel();
      cacheAccept = cacheValid;
      @(posedge clk);
      #1;
      grant = 0;
      cacheAccept = 0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] e1, e2;
`ifdef INPUT_PORT_ERROR_COUNT_EN
    e1 = 8'd1;
    e2 = 8'd2;
`else
    e1 = 8'd0;
    e2 = 8'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_outs", 32'(outs()), 0);
    check("rst_full", full, 0);
    check("rst_err", errorCount, 0);
    @(posedge clk);
    #1 reset = 1;
    // east packet: select appears after the second edge, wrong grant is ignored
    sb.push_back(pk(4'b0100, 0, 1, 0, 6'h34, 4'h5, 8'hA5));
    drive(1, 0, 6'h34, 4'h5, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("lat_route", 32'(sel()), 0);
    @(negedge clk);
    check("lat_send", 32'(outs()), 32'(pk(4'b0100, 0, 1, 0, 6'h34, 4'h5, 8'hA5)));
    @(posedge clk);
    #1 grant = 4'b0001;
    @(posedge clk);
    #1 grant = 4'b0100;
    @(negedge clk);
    check("wrong_grant_ignored", 32'(sel()), 4'b0100);
    @(posedge clk);
    #1 grant = 0;
    @(negedge clk);
    check("east_idle", 32'(outs()), 32'(pk(0, 0, 0, 0, 6'h34, 4'h5, 8'hA5)));
    // local packet held five cycles without accept
    sb.push_back(pk(4'b0000, 1, 0, 1, 6'h14, 4'h3, 8'h3C));
    drive(0, 1, 6'h14, 4'h3, 8'h3C);
    wait_valid("local_timeout");
    for (int i = 0; i < 5; i++) begin
      check("local_hold", 32'(outs()), 32'(pk(4'b0000, 1, 0, 1, 6'h14, 4'h3, 8'h3C)));
      @(negedge clk);
    end
    @(posedge clk);
    #1 cacheAccept = 1;
    @(posedge clk);
    #1 cacheAccept = 0;
    @(negedge clk);
    check("local_popped", cacheValid, 0);
    // fill: four accepted, fifth dropped
    sb.push_back(pk(4'b1000, 0, 1, 0, 6'h04, 4'h1, 8'h01));
    drive(1, 0, 6'h04, 4'h1, 8'h01);
    sb.push_back(pk(4'b0001, 0, 1, 0, 6'h10, 4'h2, 8'h02));
    drive(1, 0, 6'h10, 4'h2, 8'h02);
    sb.push_back(pk(4'b0010, 0, 0, 1, 6'h18, 4'h3, 8'h03));
    drive(0, 1, 6'h18, 4'h3, 8'h03);
    check("full_at3", full, 0);
    sb.push_back(pk(4'b0100, 0, 1, 0, 6'h34, 4'h4, 8'h04));
    drive(1, 0, 6'h34, 4'h4, 8'h04);
    check("full_at4", full, 1);
    drive(1, 0, 6'h34, 4'h5, 8'h05);
    check("full_at5", full, 1);
    check("err_overflow", errorCount, 32'(e1));
    // push while the head is granted: accepted, count stays full
    wait_valid("full_send_timeout");
    @(posedge clk);
    #1 grant = 4'b1000;
    sb.push_back(pk(4'b0000, 1, 1, 0, 6'h14, 4'h6, 8'h06));
    drive(1, 0, 6'h14, 4'h6, 8'h06);
    grant = 0;
    check("full_hold", full, 1);
    check("err_no_drop", errorCount, 32'(e1));
    drain(4);
    @(negedge clk);
    check("drained_full", full, 0);
    check("drained_sb", sb.size(), 0);
    // malformed packet is dropped and never routed
    drive(1, 1, 6'h34, 4'h7, 8'hEE);
    repeat (4) @(negedge clk);
    check("malformed_quiet", 32'(outs()), 32'(pk(0, 0, 0, 0, 6'h14, 4'h6, 8'h06)));
    check("err_malformed", errorCount, 32'(e2));
    // reset mid-SEND flushes everything
    drive(1, 0, 6'h34, 4'h8, 8'h11);
    drive(1, 0, 6'h04, 4'h8, 8'h22);
    drive(0, 1, 6'h14, 4'h8, 8'h33);
    wait_valid("rst_send_timeout");
    @(posedge clk);
    #1 reset = 0;
    #1;
    check("async_rst_outs", 32'(outs()), 0);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("post_rst_full", full, 0);
    check("post_rst_err", errorCount, 0);
    repeat (4) @(negedge clk);
    check("post_rst_flushed", 32'(outs()), 0);
    sb.push_back(pk(4'b0010, 0, 1, 0, 6'h18, 4'h9, 8'h77));
    drive(1, 0, 6'h18, 4'h9, 8'h77);
    drain(1);
    @(negedge clk);
    check("final_sb", sb.size(), 0);
    check("final_idle", 32'(sel()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
